// File: rtl/hsb_pkg.sv
// Shared constants for the hazard scoreboard: default geometry, stage indices
// and forward-select encodings.
package hsb_pkg;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int DEPTH_DEF      = 3;

  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  localparam int FWD_RF = 0;
endpackage

// File: rtl/hsb_port_match.sv
// One read port's view of the scoreboard: youngest in-flight writer of src,
// its stage, and whether its result is still too young to forward.
module hsb_port_match
  import hsb_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                                 src_en,
  input  logic [REG_ADDR_W-1:0]                src,
  input  logic [DEPTH-1:1]                     vld,
  input  logic [DEPTH-1:1][REG_ADDR_W-1:0]     dest,
  input  logic [DEPTH-1:1][SEL_W-1:0]          rdy,
  output logic                                 hit,
  output logic [SEL_W-1:0]                     stg,
  output logic                                 hazard
);

  // Oldest-to-youngest scan so the lowest matching stage is left standing.
  always_comb begin
    hit    = 1'b0;
    stg    = '0;
    hazard = 1'b0;
    for (int s = DEPTH - 1; s >= 1; s--) begin
      if (src_en && vld[s] && dest[s] == src) begin
        hit    = 1'b1;
        stg    = SEL_W'(s);
        hazard = (s + 1) < int'(rdy[s]);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Depth/port-generic stall and forwarding controller for the MIPS pipeline.
// Optional stall counter enabled by defining HSB_PERF_CNT_EN.
module hazard_scoreboard
  import hsb_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int NUM_RD_PORTS = 2,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int SEL_W        = $clog2(DEPTH + 1)
`ifdef HSB_PERF_CNT_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 valid_d,
  input  logic                                 kill_d,
  input  logic                                 hold,
  input  logic                                 wr_en_d,
  input  logic [REG_ADDR_W-1:0]                dest_d,
  input  logic [SEL_W-1:0]                     rdy_stage_d,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0]   src_d,
  input  logic [NUM_RD_PORTS-1:0]              src_use_d,
  output logic                                 stall_f,
  output logic                                 stall_d,
  output logic                                 flush_e,
  output logic [NUM_RD_PORTS*SEL_W-1:0]        fwd_sel_e
`ifdef HSB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]                     stall_cnt
`endif
);

  // Entry DEPTH is never consulted (write-first register file), so only
  // stages E..DEPTH-1 are held.
  logic [DEPTH-1:1]                     vld_pipe;
  logic [DEPTH-1:1][REG_ADDR_W-1:0]     dest_pipe;
  logic [DEPTH-1:1][SEL_W-1:0]          rdy_pipe;

  logic [NUM_RD_PORTS-1:0]              hit, hazard;
  logic [NUM_RD_PORTS-1:0][SEL_W-1:0]   stg;
  logic                                 d_live, stall, issue, rec;
  logic [SEL_W-1:0]                     rdy_clamp;
  logic [NUM_RD_PORTS*SEL_W-1:0]        fwd_nxt;

  assign d_live = valid_d & ~kill_d;

  genvar p;
  generate
    for (p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      hsb_port_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH),
        .SEL_W      (SEL_W)
      ) u_pm (
        .src_en (src_use_d[p] & d_live),
        .src    (src_d[p*REG_ADDR_W +: REG_ADDR_W]),
        .vld    (vld_pipe),
        .dest   (dest_pipe),
        .rdy    (rdy_pipe),
        .hit    (hit[p]),
        .stg    (stg[p]),
        .hazard (hazard[p])
      );
    end
  endgenerate

  assign stall   = |hazard;
  assign stall_f = hold | stall;
  assign stall_d = hold | stall;
  assign flush_e = ~hold & stall;
  assign issue   = d_live & ~stall;
  assign rec     = issue & wr_en_d & (dest_d != '0);

  always_comb begin
    rdy_clamp = rdy_stage_d;
    if (rdy_stage_d == '0 || int'(rdy_stage_d) > DEPTH) rdy_clamp = SEL_W'(DEPTH);
  end

  always_comb begin
    fwd_nxt = {NUM_RD_PORTS{SEL_W'(FWD_RF)}};
    if (issue) begin
      for (int i = 0; i < NUM_RD_PORTS; i++)
        if (hit[i]) fwd_nxt[i*SEL_W +: SEL_W] = stg[i] + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      fwd_sel_e <= {NUM_RD_PORTS{SEL_W'(FWD_RF)}};
    end else if (!hold) begin
      vld_pipe[STG_E]  <= rec;
      dest_pipe[STG_E] <= dest_d;
      rdy_pipe[STG_E]  <= rdy_clamp;
      for (int s = STG_E + 1; s <= DEPTH - 1; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        dest_pipe[s] <= dest_pipe[s-1];
        rdy_pipe[s]  <= rdy_pipe[s-1];
      end
      fwd_sel_e <= fwd_nxt;
    end
  end

`ifdef HSB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (!hold && stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed check of hazard_scoreboard against a timestamped
// list-of-writes reference model.
module tb_hazard_scoreboard;
  localparam int RW = 5;
  localparam int NP = 2;
  localparam int D  = 3;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              reset, valid_d, kill_d, hold, wr_en_d;
  logic [RW-1:0]     dest_d;
  logic [SW-1:0]     rdy_stage_d;
  logic [NP*RW-1:0]  src_d;
  logic [NP-1:0]     src_use_d;
  logic              stall_f, stall_d, flush_e;
  logic [NP*SW-1:0]  fwd_sel_e;
`ifdef HSB_PERF_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(RW), .NUM_RD_PORTS(NP), .DEPTH(D), .SEL_W(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_d     (valid_d),
    .kill_d      (kill_d),
    .hold        (hold),
    .wr_en_d     (wr_en_d),
    .dest_d      (dest_d),
    .rdy_stage_d (rdy_stage_d),
    .src_d       (src_d),
    .src_use_d   (src_use_d),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_e     (flush_e),
    .fwd_sel_e   (fwd_sel_e)
`ifdef HSB_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Model: each recorded write remembers the advance count at which it
  // entered E; its current stage is simply elapsed advances since then.
  typedef struct { int dest; int rdy; int t; } wr_t;
  wr_t q[$];
  int  adv = 0;
  int  m_fwd[NP];
  int  m_cnt = 0;
  int  n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int r, input int v, input int k, input int h, input int we,
                      input int dst, input int rd, input int s0, input int s1, input int u);
    int  best[NP], brdy[NP], srcs[NP];
    bit  stl, iss;
    reset       = 1'(r);
    valid_d     = 1'(v);
    kill_d      = 1'(k);
    hold        = 1'(h);
    wr_en_d     = 1'(we);
    dest_d      = RW'(dst);
    rdy_stage_d = SW'(rd);
    src_d       = {RW'(s1), RW'(s0)};
    src_use_d   = NP'(u);
    srcs[0] = s0; srcs[1] = s1;
    @(negedge clk);
    stl = 0;
    for (int p = 0; p < NP; p++) begin
      best[p] = 0; brdy[p] = 0;
      if (u[p] && v != 0 && k == 0) begin
        foreach (q[i]) begin
          int st;
          st = adv - q[i].t;
          if (st >= 1 && st < D && q[i].dest == srcs[p] && (best[p] == 0 || st < best[p])) begin
            best[p] = st; brdy[p] = q[i].rdy;
          end
        end
      end
      if (best[p] != 0 && best[p] + 1 < brdy[p]) stl = 1;
    end
    chk("stall_f", stall_f, (h != 0 || stl) ? 1 : 0);
    chk("stall_d", stall_d, (h != 0 || stl) ? 1 : 0);
    chk("flush_e", flush_e, (h == 0 && stl) ? 1 : 0);
    for (int p = 0; p < NP; p++)
      chk($sformatf("fwd_sel_e[%0d]", p), fwd_sel_e[p*SW +: SW], m_fwd[p]);
`ifdef HSB_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`endif
    if (r != 0) begin
      q.delete();
      foreach (m_fwd[p]) m_fwd[p] = 0;
      m_cnt = 0;
    end else if (h == 0) begin
      adv++;
      iss = (v != 0 && k == 0 && !stl);
      if (iss && we != 0 && dst != 0)
        q.push_back('{dest: dst, rdy: (rd == 0 || rd > D) ? D : rd, t: adv - 1});
      for (int p = 0; p < NP; p++) m_fwd[p] = (iss && best[p] != 0) ? best[p] + 1 : 0;
      if (stl && m_cnt < 65535) m_cnt++;
      for (int i = q.size() - 1; i >= 0; i--)
        if (adv - q[i].t > D) q.delete(i);
    end
    @(posedge clk); #1;
  endtask

  // nop: valid, no write, no reads
  task automatic nop();
    step(0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
  endtask

  initial begin
    foreach (m_fwd[p]) m_fwd[p] = 0;
    reset = 1; valid_d = 0; kill_d = 0; hold = 0; wr_en_d = 0;
    dest_d = '0; rdy_stage_d = '0; src_d = '0; src_use_d = '0;
    repeat (2) @(posedge clk);
    #1;

    // ALU result forwarded back-to-back from M
    step(0, 1, 0, 0, 1, 3, 2, 0, 0, 0);
    step(0, 1, 0, 0, 1, 5, 2, 3, 1, 3);
    nop(); nop(); nop();
    // load-use: one stall, then forward from W
    step(0, 1, 0, 0, 1, 4, 3, 0, 0, 0);
    step(0, 1, 0, 0, 1, 6, 2, 4, 4, 3);
    step(0, 1, 0, 0, 1, 6, 2, 4, 4, 3);
    nop(); nop(); nop();
    // distance 2 and 3
    step(0, 1, 0, 0, 1, 3, 2, 0, 0, 0); nop();
    step(0, 1, 0, 0, 0, 0, 2, 3, 0, 1);
    step(0, 1, 0, 0, 1, 3, 2, 0, 0, 0); nop(); nop();
    step(0, 1, 0, 0, 0, 0, 2, 3, 0, 1);
    nop(); nop(); nop();
    // youngest writer wins; r0 never tracked
    step(0, 1, 0, 0, 1, 7, 2, 0, 0, 0);
    step(0, 1, 0, 0, 1, 7, 2, 7, 0, 1);
    step(0, 1, 0, 0, 0, 0, 2, 7, 0, 1);
    step(0, 1, 0, 0, 1, 0, 3, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 2, 0, 0, 3);
    nop(); nop(); nop();
    // hold over a load-use
    step(0, 1, 0, 0, 1, 4, 3, 0, 0, 0);
    repeat (3) step(0, 1, 0, 1, 1, 6, 2, 4, 0, 1);
    step(0, 1, 0, 0, 1, 6, 2, 4, 0, 1);
    step(0, 1, 0, 0, 1, 6, 2, 4, 0, 1);
    nop(); nop(); nop();
    // kill dominates stall
    step(0, 1, 0, 0, 1, 4, 3, 0, 0, 0);
    step(0, 1, 1, 0, 1, 6, 2, 4, 4, 3);
    nop(); nop(); nop();
    // reset mid-stream
    step(0, 1, 0, 0, 1, 4, 3, 0, 0, 0);
    step(1, 1, 0, 0, 1, 6, 2, 4, 4, 3);
    step(0, 1, 0, 0, 1, 6, 2, 4, 4, 3);
    nop(); nop();

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(99) < 2) ? 1 : 0,
           ($urandom_range(99) < 85) ? 1 : 0,
           ($urandom_range(99) < 10) ? 1 : 0,
           ($urandom_range(99) < 15) ? 1 : 0,
           ($urandom_range(99) < 75) ? 1 : 0,
           int'($urandom_range(4)),
           int'($urandom_range(3)),
           int'($urandom_range(4)),
           int'($urandom_range(4)),
           int'($urandom_range(3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
